// File: rtl/fso_link_pkg.sv
// Shared definitions for the FSO link: BER sequencer states and PRBS-7 constants.
package fso_link_pkg;

  localparam int unsigned PRBS_ORDER  = 7;
  localparam int unsigned PRBS_TAP_HI = 6;
  localparam int unsigned PRBS_TAP_LO = 5;
  localparam logic [PRBS_ORDER-1:0] PRBS_SEED = 7'h7F;

  typedef enum logic [2:0] {
    StIdle,
    StTxPre,
    StSeed,
    StVerify,
    StMeasure,
    StFail,
    StDone
  } state_e;

  // x^7 + x^6 + 1 feedback term for a left-shifting register.
  function automatic logic prbs7_feedback(input logic [PRBS_ORDER-1:0] q);
    return q[PRBS_TAP_HI] ^ q[PRBS_TAP_LO];
  endfunction

endpackage

// File: rtl/prbs7_lfsr.sv
// PRBS-7 shift register with serial load, used for both the laser transmitter and the
// receive-side reference.
module prbs7_lfsr
  import fso_link_pkg::*;
#(
  // When set, o_Bit is the bit the register will generate next rather than its MSB.
  // The receive reference is seeded with the last seven received bits, so the bit it
  // expects to see next is its feedback term.
  parameter bit LOOKAHEAD = 1'b0
) (
  input  logic CLK,
  input  logic i_Reset,
  input  logic i_Load,
  input  logic i_LoadBit,
  input  logic i_Step,
  output logic o_Bit
);

  logic [PRBS_ORDER-1:0] lfsr_q;

  // Load shifts a received bit in; step shifts the generated feedback in.
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      lfsr_q <= PRBS_SEED;
    end else if (i_Load) begin
      lfsr_q <= {lfsr_q[PRBS_ORDER-2:0], i_LoadBit};
    end else if (i_Step) begin
      lfsr_q <= {lfsr_q[PRBS_ORDER-2:0], prbs7_feedback(lfsr_q)};
    end
  end

  assign o_Bit = LOOKAHEAD ? prbs7_feedback(lfsr_q) : lfsr_q[PRBS_ORDER-1];

endmodule

// File: rtl/fso_ber_test_controller.sv
// PRBS-7 bit-error-rate test sequencer for the laser FSO link: transmits the sequence,
// self-seeds a receive reference, verifies lock, then counts errors over a window.
module fso_ber_test_controller
  import fso_link_pkg::*;
#(
  parameter int unsigned BIT_DIV         = 16,
  parameter int unsigned PREAMBLE_BITS   = 32,
  parameter int unsigned SYNC_CHECK_BITS = 32,
  parameter int unsigned LOCK_ERR_MAX    = 4,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned WINDOW_BITS     = 1024,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic             i_Abort,
  input  logic             i_ReceivedSignal,
  output logic             o_PRBS,
  output logic             o_TxEnable,
  output logic             o_Busy,
  output logic             o_Locked,
  output logic             o_LockFail,
  output logic             o_Done,
  output logic [CNT_W-1:0] o_ErrorCount,
  output logic [CNT_W-1:0] o_BitCount
);

  localparam int unsigned PH_W = $clog2(BIT_DIV);
  localparam int unsigned VE_W = $clog2(SYNC_CHECK_BITS + 1);
  localparam int unsigned RT_W = $clog2(MAX_RETRIES + 1);

  state_e           state_q;
  logic [PH_W-1:0]  phase_q;
  logic [1:0]       sync_q;
  logic [31:0]      bit_idx_q;
  logic [VE_W-1:0]  verr_q;
  logic [RT_W-1:0]  retries_q;
  logic             seed_any_q;

  logic             running;
  logic             phase_last;
  logic             strobe;
  logic             rx_bit;
  logic             tx_bit;
  logic             tx_step;
  logic             rx_expect;
  logic             rx_load;
  logic             rx_step;
  logic             mismatch;
  logic             start_go;
  logic             pre_last;
  logic             seed_last;
  logic             verify_last;
  logic             window_last;
  logic             seed_zero;
  logic             verify_pass;
  logic             retry_last;
  logic [VE_W-1:0]  verr_total;

  assign running     = (state_q != StIdle);
  assign phase_last  = (phase_q == PH_W'(BIT_DIV - 1));
  assign strobe      = running && (phase_q == PH_W'(BIT_DIV / 2));
  assign rx_bit      = sync_q[1];
  assign tx_step     = running && phase_last;
  assign rx_load     = strobe && (state_q == StSeed);
  assign rx_step     = strobe && ((state_q == StVerify) || (state_q == StMeasure));
  assign mismatch    = rx_bit ^ rx_expect;
  assign start_go    = (state_q == StIdle) && i_Start && !i_Abort;
  assign pre_last    = strobe && (bit_idx_q == 32'(PREAMBLE_BITS - 1));
  assign seed_last   = strobe && (bit_idx_q == 32'(PRBS_ORDER - 1));
  assign verify_last = strobe && (bit_idx_q == 32'(SYNC_CHECK_BITS - 1));
  assign window_last = strobe && (bit_idx_q == 32'(WINDOW_BITS - 1));
  // The seed register would lock up on all zeros; a silent receiver looks like this.
  assign seed_zero   = !(seed_any_q | rx_bit);
  assign verr_total  = verr_q + VE_W'(mismatch);
  assign verify_pass = (32'(verr_total) <= 32'(LOCK_ERR_MAX));
  assign retry_last  = (32'(retries_q) == 32'(MAX_RETRIES - 1));

  prbs7_lfsr #(
    .LOOKAHEAD (1'b0)
  ) u_tx_lfsr (
    .CLK       (CLK),
    .i_Reset   (i_Reset),
    .i_Load    (1'b0),
    .i_LoadBit (1'b0),
    .i_Step    (tx_step),
    .o_Bit     (tx_bit)
  );

  prbs7_lfsr #(
    .LOOKAHEAD (1'b1)
  ) u_rx_lfsr (
    .CLK       (CLK),
    .i_Reset   (i_Reset),
    .i_Load    (rx_load),
    .i_LoadBit (rx_bit),
    .i_Step    (rx_step),
    .o_Bit     (rx_expect)
  );

  // Bit timer: parked at zero in IDLE so every run starts on a bit boundary.
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      phase_q <= '0;
    end else if (!running || i_Abort || phase_last) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + PH_W'(1);
    end
  end

  // Two-flop synchronizer for the raw photodetector input.
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_ReceivedSignal};
    end
  end

  // Sequencer: state, per-phase strobe counter, lock bookkeeping and status outputs.
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= StIdle;
      bit_idx_q  <= '0;
      verr_q     <= '0;
      retries_q  <= '0;
      seed_any_q <= 1'b0;
      o_PRBS     <= 1'b0;
      o_TxEnable <= 1'b0;
      o_Busy     <= 1'b0;
      o_Locked   <= 1'b0;
      o_LockFail <= 1'b0;
      o_Done     <= 1'b0;
    end else if (i_Abort) begin
      state_q    <= StIdle;
      o_PRBS     <= 1'b0;
      o_TxEnable <= 1'b0;
      o_Busy     <= 1'b0;
      o_Locked   <= 1'b0;
      o_Done     <= 1'b0;
    end else begin
      o_Done <= 1'b0;
      o_PRBS <= tx_bit;
      if (strobe) begin
        bit_idx_q <= bit_idx_q + 32'd1;
      end
      unique case (state_q)
        StIdle: begin
          o_PRBS <= 1'b0;
          if (i_Start) begin
            state_q    <= StTxPre;
            o_PRBS     <= tx_bit;
            o_TxEnable <= 1'b1;
            o_Busy     <= 1'b1;
            o_Locked   <= 1'b0;
            o_LockFail <= 1'b0;
            retries_q  <= '0;
            bit_idx_q  <= '0;
            verr_q     <= '0;
          end
        end
        StTxPre: begin
          if (pre_last) begin
            state_q    <= StSeed;
            bit_idx_q  <= '0;
            seed_any_q <= 1'b0;
          end
        end
        StSeed: begin
          if (strobe) begin
            seed_any_q <= seed_any_q | rx_bit;
          end
          if (seed_last) begin
            bit_idx_q <= '0;
            verr_q    <= '0;
            if (seed_zero) begin
              retries_q  <= retries_q + RT_W'(1);
              seed_any_q <= 1'b0;
              if (retry_last) begin
                state_q    <= StFail;
                o_LockFail <= 1'b1;
              end else begin
                state_q <= StSeed;
              end
            end else begin
              state_q <= StVerify;
            end
          end
        end
        StVerify: begin
          if (strobe) begin
            verr_q <= verr_total;
          end
          if (verify_last) begin
            bit_idx_q <= '0;
            if (verify_pass) begin
              state_q  <= StMeasure;
              o_Locked <= 1'b1;
            end else begin
              retries_q  <= retries_q + RT_W'(1);
              seed_any_q <= 1'b0;
              if (retry_last) begin
                state_q    <= StFail;
                o_LockFail <= 1'b1;
              end else begin
                state_q <= StSeed;
              end
            end
          end
        end
        StMeasure: begin
          if (window_last) begin
            state_q <= StDone;
            o_Done  <= 1'b1;
          end
        end
        StFail: begin
          state_q <= StDone;
          o_Done  <= 1'b1;
        end
        StDone: begin
          state_q    <= StIdle;
          o_PRBS     <= 1'b0;
          o_TxEnable <= 1'b0;
          o_Busy     <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Measurement statistics: cleared by a start, saturating, held otherwise.
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      o_ErrorCount <= '0;
      o_BitCount   <= '0;
    end else if (start_go) begin
      o_ErrorCount <= '0;
      o_BitCount   <= '0;
    end else if ((state_q == StMeasure) && strobe && !i_Abort) begin
      if (o_BitCount != '1) begin
        o_BitCount <= o_BitCount + CNT_W'(1);
      end
      if (mismatch && (o_ErrorCount != '1)) begin
        o_ErrorCount <= o_ErrorCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fso_ber_test_controller.sv
// Bench for fso_ber_test_controller: optical loopback with injectable inversions, a
// per-DUT queue of expected end-of-run results and a monitor that checks each o_Done.
module tb_fso_ber_test_controller;

  localparam int unsigned BD = 4;

  typedef struct packed {
    logic        locked;
    logic        lockfail;
    logic [15:0] err;
    logic [15:0] bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start16 = 1'b0;
  logic start8 = 1'b0;
  logic abort = 1'b0;
  logic inv16 = 1'b0;
  logic inv8 = 1'b0;
  logic hold16 = 1'b0;
  logic prbs_d16 = 1'b0;
  logic prbs_d8 = 1'b0;
  logic rx16;
  logic rx8;

  logic        prbs16, txen16, busy16, locked16, lockfail16, done16;
  logic [15:0] err16, bits16;
  logic        prbs8, txen8, busy8, locked8, lockfail8, done8;
  logic [7:0]  err8, bits8;

  int n_checks = 0;
  int n_fail = 0;
  exp_t q16[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  // Loopback channel: one cycle of flight, optional inversion or dead receiver.
  always @(posedge clk) begin
    prbs_d16 <= prbs16;
    prbs_d8  <= prbs8;
  end
  assign rx16 = hold16 ? 1'b0 : (prbs_d16 ^ inv16);
  assign rx8  = prbs_d8 ^ inv8;

  fso_ber_test_controller #(
    .BIT_DIV (BD),
    .CNT_W   (16)
  ) dut16 (
    .CLK              (clk),
    .i_Reset          (rst),
    .i_Start          (start16),
    .i_Abort          (abort),
    .i_ReceivedSignal (rx16),
    .o_PRBS           (prbs16),
    .o_TxEnable       (txen16),
    .o_Busy           (busy16),
    .o_Locked         (locked16),
    .o_LockFail       (lockfail16),
    .o_Done           (done16),
    .o_ErrorCount     (err16),
    .o_BitCount       (bits16)
  );

  fso_ber_test_controller #(
    .BIT_DIV (BD),
    .CNT_W   (8)
  ) dut8 (
    .CLK              (clk),
    .i_Reset          (rst),
    .i_Start          (start8),
    .i_Abort          (abort),
    .i_ReceivedSignal (rx8),
    .o_PRBS           (prbs8),
    .o_TxEnable       (txen8),
    .o_Busy           (busy8),
    .o_Locked         (locked8),
    .o_LockFail       (lockfail8),
    .o_Done           (done8),
    .o_ErrorCount     (err8),
    .o_BitCount       (bits8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitors: every o_Done pulse must match the oldest expected run result.
  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done16_unexpected: actual o_Done=1, required 0");
      end else begin
        e = q16.pop_front();
        check("run16_locked", 32'(locked16), 32'(e.locked));
        check("run16_lockfail", 32'(lockfail16), 32'(e.lockfail));
        check("run16_errors", 32'(err16), 32'(e.err));
        check("run16_bits", 32'(bits16), 32'(e.bits));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done8_unexpected: actual o_Done=1, required 0");
      end else begin
        e = q8.pop_front();
        check("run8_locked", 32'(locked8), 32'(e.locked));
        check("run8_lockfail", 32'(lockfail8), 32'(e.lockfail));
        check("run8_errors", 32'(err8), 32'(e.err));
        check("run8_bits", 32'(bits8), 32'(e.bits));
      end
    end
  end

  task automatic go16();
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic wait_lock16(input int budget, output int c);
    c = 0;
    while (!locked16 && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic drain16(input int budget);
    int c = 0;
    while (q16.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (q16.size() != 0) begin
      n_fail++;
      $display("FAIL drain16: actual %0d runs pending, required 0", q16.size());
      q16.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic drain8(input int budget);
    int c = 0;
    while (q8.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (q8.size() != 0) begin
      n_fail++;
      $display("FAIL drain8: actual %0d runs pending, required 0", q8.size());
      q8.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    int c;
    repeat (3) @(negedge clk);
    check("rst_prbs", 32'(prbs16), 0);
    check("rst_txen", 32'(txen16), 0);
    check("rst_busy", 32'(busy16), 0);
    check("rst_locked", 32'(locked16), 0);
    check("rst_lockfail", 32'(lockfail16), 0);
    check("rst_done", 32'(done16), 0);
    check("rst_errors", 32'(err16), 0);
    check("rst_bits", 32'(bits16), 0);
    check("rst_txen8", 32'(txen8), 0);
    check("rst_busy8", 32'(busy8), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: clean loopback; lock after 32+7+32 bits, full window, no errors.
    q16.push_back('{locked: 1'b1, lockfail: 1'b0, err: 16'd0, bits: 16'd1024});
    go16();
    check("t1_txen_on_start", 32'(txen16), 1);
    check("t1_busy_on_start", 32'(busy16), 1);
    wait_lock16(2000, c);
    check("t1_lock_cycle_in_range", 32'(c >= 276 && c <= 292), 1);
    drain16(6000);
    check("t1_idle_txen", 32'(txen16), 0);
    check("t1_idle_prbs", 32'(prbs16), 0);

    // 2: five single-bit inversions in MEASURE.
    q16.push_back('{locked: 1'b1, lockfail: 1'b0, err: 16'd5, bits: 16'd1024});
    go16();
    wait_lock16(2000, c);
    for (int k = 0; k < 5; k++) begin
      repeat (200) @(negedge clk);
      inv16 = 1'b1;
      repeat (BD) @(negedge clk);
      inv16 = 1'b0;
    end
    drain16(6000);

    // 3: dead receiver; all-zero seed three times gives a lock failure.
    hold16 = 1'b1;
    q16.push_back('{locked: 1'b0, lockfail: 1'b1, err: 16'd0, bits: 16'd0});
    go16();
    drain16(2000);
    hold16 = 1'b0;

    // 4: ten bad bits in the first VERIFY force one re-seed.
    q16.push_back('{locked: 1'b1, lockfail: 1'b0, err: 16'd0, bits: 16'd1024});
    go16();
    repeat (188) @(negedge clk);
    inv16 = 1'b1;
    repeat (10 * BD) @(negedge clk);
    inv16 = 1'b0;
    wait_lock16(2000, c);
    c += 188 + 10 * BD;
    check("t4_relock_cycle_in_range", 32'(c >= 428 && c <= 452), 1);
    drain16(6000);

    // 5: 8-bit counters, receiver inverted after lock; both counters saturate.
    q8.push_back('{locked: 1'b1, lockfail: 1'b0, err: 16'd255, bits: 16'd255});
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    c = 0;
    while (!locked8 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    inv8 = 1'b1;
    drain8(6000);
    inv8 = 1'b0;

    // 6a: abort mid-MEASURE; idle next cycle and no o_Done afterwards.
    go16();
    wait_lock16(2000, c);
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy16), 0);
    check("abort_txen", 32'(txen16), 0);
    check("abort_prbs", 32'(prbs16), 0);
    check("abort_locked", 32'(locked16), 0);
    check("abort_errors_held", 32'(err16), 0);
    repeat (200) @(negedge clk);

    // Start and abort together: abort wins.
    start16 = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    abort   = 1'b0;
    check("start_abort_busy", 32'(busy16), 0);
    check("start_abort_txen", 32'(txen16), 0);

    // 6b: asynchronous reset mid-VERIFY clears outputs without a clock edge.
    go16();
    repeat (180) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("areset_busy", 32'(busy16), 0);
    check("areset_txen", 32'(txen16), 0);
    check("areset_prbs", 32'(prbs16), 0);
    check("areset_locked", 32'(locked16), 0);
    check("areset_bits", 32'(bits16), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A fresh start after reset runs to completion.
    q16.push_back('{locked: 1'b1, lockfail: 1'b0, err: 16'd0, bits: 16'd1024});
    go16();
    drain16(6000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
